// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: signal bundle between the add job sequencer and its neighbours.
//   in_*    : operand pairs from the register front-end (valid/ready)
//   add_*   : operands/enable out to `add`, done/sum back from it
//   res_*   : captured result towards the consumer (valid/ready)
//   busy, job_cnt, err : status
// Modports:
//   master : the sequencer side (add_seq_ctrl)
//   slave  : the environment side (front-end, `add`, result consumer)
interface add_seq_ctrl_if #(
    parameter int unsigned WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_num1;
    logic [WIDTH-1:0] add_num2;
    logic             add_enable;
    logic             add_done;
    logic [WIDTH-1:0] add_sum;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             busy;
    logic [7:0]       job_cnt;
    logic             err;

    modport master (
        input  in_valid, in_a, in_b, add_done, add_sum, res_ready,
        output in_ready, add_num1, add_num2, add_enable,
               res_valid, res_sum, busy, job_cnt, err
    );

    modport slave (
        output in_valid, in_a, in_b, add_done, add_sum, res_ready,
        input  in_ready, add_num1, add_num2, add_enable,
               res_valid, res_sum, busy, job_cnt, err
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: upstream job sequencer for the `add` operator.
// Buffers operand pairs in a DEPTH-entry FIFO, issues them one at a time to
// `add` (registered num1/num2 plus a one-cycle enable), waits for the full
// done pulse, captures sum on done's falling edge and holds it on the result
// port until accepted.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : add_seq_ctrl_if.master (operand input, add interface, result
//           output, busy/job_cnt/err status)
// Parameters: WIDTH (operand/sum width), DEPTH (FIFO entries, power of two,
//   >=2), TIMEOUT (watchdog limit in cycles).
// Optional feature: define ADD_SEQ_TIMEOUT_EN to enable the watchdog that
//   abandons a job when done does not complete within TIMEOUT cycles and sets
//   the sticky err flag. Without it the wait states wait forever, err = 0.
module add_seq_ctrl #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           reset,
    add_seq_ctrl_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t state_q, state_d;

    // Operand FIFO
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop, empty;

    // Job / result registers
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic             enable_q, enable_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic [7:0]       job_cnt_q, job_cnt_d;

`ifdef ADD_SEQ_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT) + 1;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
`endif

    assign push  = bus.in_valid && in_ready_q;
    assign empty = (count_q == '0);

    // in_ready is registered from the next occupancy, so a pop only frees
    // the slot for pushes from the following cycle.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            if (push) begin
                mem_a_q[wr_ptr_q] <= bus.in_a;
                mem_b_q[wr_ptr_q] <= bus.in_b;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        enable_d    = 1'b0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        job_cnt_d   = job_cnt_q;
        pop         = 1'b0;
`ifdef ADD_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif

        if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // A late done from an abandoned job also holds off issue.
                if (!empty && !res_valid_q && !bus.add_done) begin
                    num1_d   = mem_a_q[rd_ptr_q];
                    num2_d   = mem_b_q[rd_ptr_q];
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_HI;
`ifdef ADD_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT_HI: begin
                if (bus.add_done) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                // `add` updates sum only after done rises, so the stable
                // value is taken on done's falling edge.
                if (!bus.add_done) begin
                    res_sum_d   = bus.add_sum;
                    res_valid_d = 1'b1;
                    pop         = 1'b1;
                    job_cnt_d   = job_cnt_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ADD_SEQ_TIMEOUT_EN
        // Normal completion in the same cycle takes priority over expiry.
        if ((state_q == S_WAIT_HI || state_q == S_WAIT_LO) && state_d != S_IDLE) begin
            if (wdog_q == WDW'(TIMEOUT)) begin
                pop     = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num1_q      <= '0;
            num2_q      <= '0;
            enable_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            job_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            enable_q    <= enable_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            job_cnt_q   <= job_cnt_d;
        end
    end

`ifdef ADD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.add_num1   = num1_q;
    assign bus.add_num2   = num2_q;
    assign bus.add_enable = enable_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sum    = res_sum_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.job_cnt    = job_cnt_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed self-checking bench for add_seq_ctrl.
// Includes a small `add` responder: done rises LAT cycles after enable, stays
// high 3 cycles, and sum is updated one cycle after done rises.
module tb_add_seq_ctrl;
    localparam int unsigned WIDTH = 3;
    localparam int unsigned LAT   = 1024;

    logic clk;
    logic reset;
    int   n_err;
    int   n_chk;
    bit   model_en;

    add_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add_seq_ctrl #(
        .WIDTH  (WIDTH),
        .DEPTH  (4),
        .TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // `add` responder, sharing the reset net
    logic             m_act;
    int unsigned      m_cnt;
    logic [WIDTH-1:0] m_a, m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act        <= 1'b0;
            m_cnt        <= 0;
            m_a          <= '0;
            m_b          <= '0;
            bus.add_done <= 1'b0;
            bus.add_sum  <= '0;
        end else if (m_act) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) bus.add_done <= 1'b1;
            if (m_cnt == LAT)     bus.add_sum  <= m_a + m_b;
            if (m_cnt == LAT + 2) begin
                bus.add_done <= 1'b0;
                m_act        <= 1'b0;
            end
        end else if (bus.add_enable && model_en) begin
            m_act <= 1'b1;
            m_cnt <= 0;
            m_a   <= bus.add_num1;
            m_b   <= bus.add_num2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int budget, output bit ok);
        ok         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int n = 0; n < budget; n++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [WIDTH-1:0] exp);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        chk({tag, "_sum"}, 32'(bus.res_sum), 32'(exp));
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic wait_enable(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus.add_enable) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_enable_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        bit stable;
        bit activity;
        logic [WIDTH-1:0] ea [5];
        logic [WIDTH-1:0] eb [5];
        logic [WIDTH-1:0] es [5];

        n_err        = 0;
        n_chk        = 0;
        model_en     = 1'b1;
        reset        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst_num1",      32'(bus.add_num1),   32'd0);
        chk("rst_num2",      32'(bus.add_num2),   32'd0);
        chk("rst_enable",    32'(bus.add_enable), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid),  32'd0);
        chk("rst_res_sum",   32'(bus.res_sum),    32'd0);
        chk("rst_busy",      32'(bus.busy),       32'd0);
        chk("rst_job_cnt",   32'(bus.job_cnt),    32'd0);
        chk("rst_err",       32'(bus.err),        32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single job 3+2
        push(3'd3, 3'd2, 10, ok);
        chk("single_push", 32'(ok), 32'd1);
        wait_enable("single");
        chk("single_num1", 32'(bus.add_num1), 32'd3);
        chk("single_num2", 32'(bus.add_num2), 32'd2);
        @(negedge clk);
        chk("single_enable_pulse", 32'(bus.add_enable), 32'd0);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_num1_hold", 32'(bus.add_num1), 32'd3);
        for (int n = 0; n < 3000 && !bus.res_valid; n++) @(negedge clk);
        chk("single_job_cnt", 32'(bus.job_cnt), 32'd1);
        chk("single_idle", 32'(bus.busy), 32'd0);
        collect("single", 3'd5);

        // Wrap 7+6 -> 5, held result blocks the next issue
        push(3'd7, 3'd6, 10, ok);
        chk("wrap_push", 32'(ok), 32'd1);
        for (int n = 0; n < 3000 && !bus.res_valid; n++) @(negedge clk);
        chk("wrap_valid", 32'(bus.res_valid), 32'd1);
        push(3'd1, 3'd1, 10, ok);
        chk("wrap_push2", 32'(ok), 32'd1);
        stable = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (!bus.res_valid || bus.res_sum != 3'd5 || bus.add_enable || bus.busy)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("wrap_hold_stable", 32'(stable), 32'd1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("wrap_consumed", 32'(bus.res_valid), 32'd0);
        collect("after_hold", 3'd2);
        chk("wrap_job_cnt", 32'(bus.job_cnt), 32'd3);

        // Back-pressure: five back-to-back pushes into a 4-deep FIFO
        ea[0] = 3'd1; eb[0] = 3'd1; es[0] = 3'd2;
        ea[1] = 3'd2; eb[1] = 3'd2; es[1] = 3'd4;
        ea[2] = 3'd3; eb[2] = 3'd3; es[2] = 3'd6;
        ea[3] = 3'd0; eb[3] = 3'd1; es[3] = 3'd1;
        ea[4] = 3'd4; eb[4] = 3'd3; es[4] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            push(ea[i], eb[i], 10, ok);
            chk("bp_push", 32'(ok), 32'd1);
        end
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        push(ea[4], eb[4], 3000, ok);
        chk("bp_push5", 32'(ok), 32'd1);
        chk("bp_first_done", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 5; i++) collect($sformatf("bp_res%0d", i), es[i]);
        chk("bp_job_cnt", 32'(bus.job_cnt), 32'd8);

        // Reset mid-job
        push(3'd2, 3'd3, 10, ok);
        wait_enable("mid");
        push(3'd5, 3'd5, 10, ok);
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",     32'(bus.busy),       32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready),   32'd1);
        chk("mid_rst_num1",     32'(bus.add_num1),   32'd0);
        chk("mid_rst_num2",     32'(bus.add_num2),   32'd0);
        chk("mid_rst_job_cnt",  32'(bus.job_cnt),    32'd0);
        chk("mid_rst_valid",    32'(bus.res_valid),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        activity = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            if (bus.res_valid || bus.add_enable || bus.busy) activity = 1'b1;
            @(negedge clk);
        end
        chk("mid_no_activity", 32'(activity), 32'd0);

        // Unresponsive `add`
        model_en = 1'b0;
        push(3'd4, 3'd4, 10, ok);
        chk("to_push", 32'(ok), 32'd1);
`ifdef ADD_SEQ_TIMEOUT_EN
        for (int n = 0; n < 200 && !bus.err; n++) @(negedge clk);
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_job_cnt", 32'(bus.job_cnt), 32'd0);
        chk("to_no_result", 32'(bus.res_valid), 32'd0);
        repeat (5) @(negedge clk);
        model_en = 1'b1;
        push(3'd2, 3'd1, 10, ok);
        collect("to_next", 3'd3);
        chk("to_next_job_cnt", 32'(bus.job_cnt), 32'd1);
        chk("to_err_sticky", 32'(bus.err), 32'd1);
`else
        repeat (300) @(negedge clk);
        chk("stall_busy", 32'(bus.busy), 32'd1);
        chk("stall_err", 32'(bus.err), 32'd0);
        chk("stall_no_result", 32'(bus.res_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Upstream job sequencer for the `add` operator. Buffers operand pairs from a valid/ready source in a small FIFO and issues them one at a time to `add`. For each job it drives `num1`, `num2` and a one-cycle `enable`, waits for the full `done` pulse, captures `sum` and presents it on a valid/ready result port. It sits between the Wishbone/LA register front-end and the `add` instance.

Parameters:
- WIDTH, 3: operand and sum width; must match `add`.
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- TIMEOUT, 4096: watchdog limit in cycles; used only with ADD_SEQ_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO not full.
- in_a  input  WIDTH  operand 1.
- in_b  input  WIDTH  operand 2.
- add_num1  output  WIDTH  to `add.num1`, registered.
- add_num2  output  WIDTH  to `add.num2`, registered.
- add_enable  output  1  to `add.enable`, registered one-cycle pulse.
- add_done  input  1  from `add.done`.
- add_sum  input  WIDTH  from `add.sum`.
- res_valid  output  1  result held.
- res_ready  input  1  consumer accepts.
- res_sum  output  WIDTH  captured sum.
- busy  output  1  FSM not in IDLE.
- job_cnt  output  8  completed jobs, wraps 255→0.
- err  output  1  sticky timeout flag; tied 0 without the macro.

Behaviour:
- Reset values:
  - FIFO empty, in_ready=1.
  - add_num1=add_num2=0, add_enable=0.
  - res_valid=0, res_sum=0, busy=0, job_cnt=0, err=0.
  - FSM state IDLE.
- Reset is asynchronous. Assertion mid-job abandons the job immediately and drops all FIFO contents. `add` shares the reset net.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, registered; it does not rise combinationally on a same-cycle pop.
  - Pop happens only at job completion or timeout.
  - Push into an empty FIFO is visible to the FSM the next cycle.
- FSM states:
  - IDLE:
    - Condition to issue: FIFO non-empty && res_valid==0 && add_done==0.
    - On issue: latch the FIFO head into add_num1/add_num2, set add_enable=1, go to ISSUE.
  - ISSUE: add_enable←0, go to WAIT_HI. add_enable is therefore high for exactly one cycle.
  - WAIT_HI: stay until add_done==1, then go to WAIT_LO.
  - WAIT_LO: stay until add_done==0. In that cycle:
    - res_sum←add_sum, res_valid←1.
    - Pop the FIFO.
    - job_cnt←job_cnt+1.
    - Go to IDLE.
  - Capture is on the falling edge of done because `add` updates `sum` only after `done` rises.
- add_num1/add_num2 hold their value from issue until the next issue; they are stable for the whole job.
- Result port: res_valid stays high, and res_sum is stable, until a cycle with res_ready=1. res_valid clears at that edge. No new job issues while res_valid=1. Capture and consume can never coincide.
- Arithmetic: the sum passes through unmodified at WIDTH bits (`add` wraps mod 2^WIDTH). job_cnt wraps silently.
- busy = (state != IDLE).
- Latency: operand accept to res_valid is about the `add` busy time (~1027 cycles) plus 4 cycles of sequencer overhead.
- Illegal states decode to IDLE.

Optional Feature:
- Macro: ADD_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter of $clog2(TIMEOUT)+1 bits clears at ISSUE and increments in WAIT_HI and WAIT_LO.
  - When it reaches TIMEOUT: pop the job with no result, leave job_cnt unchanged, set err=1 (sticky until reset), return to IDLE.
  - A late add_done blocks further issues via the add_done==0 guard.
- Undefined: no counter; WAIT states wait indefinitely; err is constant 0.

Test Plan:
- Single job: push a=3, b=2. The `add` model raises done for 3 cycles, 1024 cycles after enable, with sum=5. Expect one-cycle add_enable, res_valid=1 with res_sum=5, job_cnt=1, busy=0 afterwards.
- Wrap: a=7, b=6 → res_sum=5. Hold res_ready=0 for 50 cycles → res_valid and res_sum stable and no second issue. Then res_ready=1 → res_valid falls the next cycle.
- Back-pressure: push 5 pairs back-to-back with DEPTH=4 → in_ready low after the 4th accept. The 5th is taken after the first job completes. Results appear in push order (1+1, 2+2, 3+3, 0+1, 4+3 → 2, 4, 6, 1, 7).
- Reset mid-job: assert reset in WAIT_HI → all outputs return to reset values asynchronously without waiting for a clock, FIFO empty, and no result after release.
- Timeout (macro on, TIMEOUT=64): the model never raises done → after 64 cycles err=1, FIFO head dropped, job_cnt unchanged, next job issues.
- Macro off: the same stimulus leaves busy=1 and err=0 indefinitely.
